// File: rtl/wallace_acc_stage.sv
// wallace_acc_stage
//   First clocked stage after the 16x16 Wallace-tree multiplier. It accepts
//   unsigned 2N-bit products as a valid/ready beat stream and accumulates them
//   into an ACC_W-bit running sum. On a beat marked last it emits the packet
//   sum, the saturating beat count and an overflow flag through a registered
//   output that holds under backpressure.
//
// Optional feature macro: WALLACE_ACC_SAT_EN
//   defined   : accumulator and result saturate to all-ones on carry out
//   undefined : accumulator wraps modulo 2^ACC_W (overflow still flagged)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   acc_clr    in   synchronous abort of the in-progress packet
//   in_prod    in   2N-bit unsigned product
//   in_valid   in   in_prod valid
//   in_last    in   current beat closes its packet
//   in_ready   out  beat can be accepted this cycle
//   out_sum    out  packet sum (ACC_W bits)
//   out_count  out  beats in packet, saturating (CNT_W bits)
//   out_ovf    out  accumulation exceeded ACC_W bits
//   out_valid  out  out_* fields valid
//   out_ready  in   consumer accepts the result
module wallace_acc_stage #(
  parameter int N     = 16,
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               acc_clr,
  input  logic [2*N-1:0]     in_prod,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_ovf,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic [ACC_W-1:0]   out_sum_q;
  logic [CNT_W-1:0]   out_count_q;
  logic               out_ovf_q;
  logic               out_valid_q;

  logic               beat;
  logic               fresh;
  logic [ACC_W-1:0]   acc_base;
  logic [CNT_W-1:0]   cnt_base;
  logic               ovf_base;
  logic [ACC_W:0]     sum_ext;
  logic               carry;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               ovf_d;

  // Ready only depends on the output slot being free or draining this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign beat     = in_valid && in_ready;

  always_comb begin
    // A clear in the same cycle as a beat takes effect first, so the beat is
    // accumulated onto an empty packet.
    fresh    = acc_clr || (state_q == IDLE);
    acc_base = fresh ? '0 : acc_q;
    cnt_base = fresh ? '0 : cnt_q;
    ovf_base = fresh ? 1'b0 : ovf_q;

    sum_ext  = {1'b0, acc_base} + {{(ACC_W+1-2*N){1'b0}}, in_prod};
    carry    = sum_ext[ACC_W];

`ifdef WALLACE_ACC_SAT_EN
    // Once saturated, any further add either carries again or adds zero, so
    // the accumulator naturally stays pinned at all-ones.
    acc_d    = carry ? '1 : sum_ext[ACC_W-1:0];
`else
    acc_d    = sum_ext[ACC_W-1:0];
`endif

    cnt_d    = (cnt_base == '1) ? cnt_base : cnt_base + CNT_ONE;
    ovf_d    = ovf_base | carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (acc_clr) begin
        state_q <= IDLE;
        acc_q   <= '0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end

      if (beat) begin
        if (in_last) begin
          // Closing beat: publish result and start the next packet empty.
          // A beat here implies the output slot is free or handshaking now.
          out_sum_q   <= acc_d;
          out_count_q <= cnt_d;
          out_ovf_q   <= ovf_d;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
          acc_q       <= '0;
          cnt_q       <= '0;
          ovf_q       <= 1'b0;
        end else begin
          state_q <= ACCUM;
          acc_q   <= acc_d;
          cnt_q   <= cnt_d;
          ovf_q   <= ovf_d;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_wallace_acc_stage.sv
module tb_wallace_acc_stage;

  localparam int N     = 16;
  localparam int ACC_W = 32;
  localparam int CNT_W = 2;
  localparam logic [63:0] ACC_MAX = (64'd1 << ACC_W) - 64'd1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             acc_clr;
  logic [2*N-1:0]   in_prod;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the packet is tracked as an exact mathematical sum and
  // beat count; only when a result is produced is it folded into ACC_W bits.
  logic [63:0]      m_sum;
  int               m_n;
  bit               m_ov;
  logic [ACC_W-1:0] m_osum;
  logic [CNT_W-1:0] m_ocnt;
  bit               m_oovf;

  wallace_acc_stage #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .acc_clr   (acc_clr),
    .in_prod   (in_prod),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [ACC_W-1:0] fold_sum(input logic [63:0] s);
    logic [ACC_W-1:0] r;
`ifdef WALLACE_ACC_SAT_EN
    r = (s > ACC_MAX) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    r = s[ACC_W-1:0];
`endif
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] fold_cnt(input int n);
    int c;
    c = (n > CNT_MAX) ? CNT_MAX : n;
    return c[CNT_W-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out();
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("out_sum",   64'(out_sum),   64'(m_osum));
    check("out_count", 64'(out_count), 64'(m_ocnt));
    check("out_ovf",   64'(out_ovf),   64'(m_oovf));
  endtask

  task automatic model_reset();
    m_sum  = 64'd0;
    m_n    = 0;
    m_ov   = 1'b0;
    m_osum = '0;
    m_ocnt = '0;
    m_oovf = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, check ready, let the rising
  // edge happen, update the model, then check outputs at the next falling edge.
  task automatic step(input bit v, input bit last, input bit clr,
                      input logic [2*N-1:0] prod, input bit ordy);
    bit m_ready;
    bit acc_ok;
    in_valid  = v;
    in_last   = last;
    acc_clr   = clr;
    in_prod   = prod;
    out_ready = ordy;
    m_ready   = !m_ov || ordy;
    #1;
    check("in_ready", 64'(in_ready), 64'(m_ready));
    @(posedge clk);
    acc_ok = v && m_ready;
    if (clr) begin
      m_sum = 64'd0;
      m_n   = 0;
    end
    if (acc_ok) begin
      m_sum = m_sum + 64'(prod);
      m_n++;
      if (last) begin
        m_ov   = 1'b1;
        m_osum = fold_sum(m_sum);
        m_ocnt = fold_cnt(m_n);
        m_oovf = (m_sum > ACC_MAX);
        $display("packet done: beats=%0d sum=%0h ovf=%0b", m_n, m_osum, m_oovf);
        m_sum  = 64'd0;
        m_n    = 0;
      end
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    @(negedge clk);
    check_out();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    acc_clr   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_prod   = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_out();
    check("in_ready_rst", 64'(in_ready), 64'd1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    @(negedge clk);
    do_reset();

    // 3 + 5 + 7, result valid for one cycle
    step(1, 0, 0, 32'd3, 1);
    step(1, 0, 0, 32'd5, 1);
    step(1, 1, 0, 32'd7, 1);
    check("sum15", 64'(out_sum), 64'd15);
    step(0, 0, 0, 32'd0, 1);

    // largest 16x16 product as a single-beat packet
    step(1, 1, 0, 32'hFFFE0001, 1);
    check("count1", 64'(out_count), 64'd1);
    step(0, 0, 0, 32'd0, 1);

    // packet A held by backpressure, then packet B reloads on the handshake
    step(1, 0, 0, 32'd2, 1);
    step(1, 1, 0, 32'd3, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 32'd9, 0);
    step(1, 1, 0, 32'd9, 1);
    check("reload9", 64'(out_sum), 64'd9);
    step(0, 0, 0, 32'd0, 1);

    // carry out of ACC_W bits
    step(1, 0, 0, 32'hFFFFFFFF, 1);
    step(1, 1, 0, 32'd2, 1);
    step(0, 0, 0, 32'd0, 1);

    // abort together with a last beat
    step(1, 0, 0, 32'd10, 1);
    step(1, 0, 0, 32'd20, 1);
    step(1, 1, 1, 32'd4, 1);
    check("clr_sum4", 64'(out_sum), 64'd4);
    step(0, 0, 0, 32'd0, 1);

    // count saturation: five beats into a 2-bit counter
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'd1, 1);
    step(1, 1, 0, 32'd1, 1);
    check("satcnt", 64'(out_count), 64'd3);

    // asynchronous reset in the middle of a packet while a result is pending
    step(1, 0, 0, 32'd6, 0);
    step(1, 0, 0, 32'd7, 0);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 32'd1, 1);
    step(1, 1, 0, 32'd2, 1);
    check("after_rst_sum", 64'(out_sum), 64'd3);
    step(0, 0, 0, 32'd0, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit v, l, c, r;
      logic [2*N-1:0] p;
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 100));
      step(v, l, c, p, r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
